// File: rtl/r4_sqrt_iter_ctrl.sv
// ---------------------------------------------------------------------------
// r4_sqrt_iter_ctrl
//   Sequencing controller for the radix-4 scalar fpsqrt iteration datapath.
//   An accepted operation walks INIT -> ITER x ITER_NUM -> POST -> DONE.
//   Special operands (zero/inf/nan/neg) skip straight to POST. The
//   controller also owns the {a0,a2,a3,a4} select register that feeds the
//   QDS constants generator (r4_qds_cg).
//
// Ports
//   clk, rst           clock, asynchronous active-high reset
//   start_valid_i/     operation request handshake
//   start_ready_o
//   early_finish_i     special operand, sampled only on the start handshake
//   flush_i            synchronous abort back to IDLE
//   root_msb_i         {a0,a2,a3,a4} from the partial-root register
//   cg_sel_o           registered {a0,a2,a3,a4} to r4_qds_cg
//   init_o             datapath loads initial residual/root
//   iter_en_o          datapath performs one radix-4 iteration
//   iter_cnt_o         0-based index of the current iteration
//   post_en_o          datapath normalises/rounds
//   finish_valid_o/    result handshake
//   finish_ready_i
//   busy_o             controller is not idle
// ---------------------------------------------------------------------------
module r4_sqrt_iter_ctrl #(
    parameter int unsigned ITER_NUM     = 13,
    parameter int unsigned CG_UPD_ITERS = 2,
    parameter int unsigned CNT_W        = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start_valid_i,
    output logic             start_ready_o,
    input  logic             early_finish_i,
    input  logic             flush_i,
    input  logic [3:0]       root_msb_i,
    output logic [3:0]       cg_sel_o,
    output logic             init_o,
    output logic             iter_en_o,
    output logic [CNT_W-1:0] iter_cnt_o,
    output logic             post_en_o,
    output logic             finish_valid_o,
    input  logic             finish_ready_i,
    output logic             busy_o
);

    typedef enum logic [2:0] {
        IDLE,
        INIT,
        ITER,
        POST,
        DONE
    } state_t;

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(ITER_NUM - 1);
    localparam logic [CNT_W-1:0] CG_LIM   = CNT_W'(CG_UPD_ITERS);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] iter_cnt_q;
    logic [3:0]       cg_sel_q;
    logic             special_q;

    logic accept;
    logic last_iter;
    logic cg_upd;

    assign accept    = start_valid_i & start_ready_o;
    assign last_iter = (iter_cnt_q == LAST_CNT);
    assign cg_upd    = (iter_cnt_q < CG_LIM);

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; flush overrides every transition
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (accept) state_d = early_finish_i ? POST : INIT;
            INIT: state_d = ITER;
            ITER: if (last_iter) state_d = POST;
            POST: state_d = DONE;
            DONE: if (finish_ready_i) state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (flush_i) begin
            state_d = IDLE;
        end
    end

    // Iteration counter, QDS select and special-operand flag.
    // cg_sel deliberately holds across a flush so the constants generator
    // keeps a stable input while the datapath is being aborted.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            iter_cnt_q <= '0;
            cg_sel_q   <= '0;
            special_q  <= 1'b0;
        end else if (flush_i) begin
            iter_cnt_q <= '0;
            special_q  <= 1'b0;
        end else begin
            if (accept) begin
                special_q <= early_finish_i;
            end
            case (state_q)
                INIT: begin
                    cg_sel_q   <= root_msb_i;
                    iter_cnt_q <= '0;
                end
                ITER: begin
                    if (cg_upd) begin
                        cg_sel_q <= root_msb_i;
                    end
                    iter_cnt_q <= last_iter ? '0 : iter_cnt_q + CNT_W'(1);
                end
                default: ;
            endcase
        end
    end

    // Output decode: everything comes from registered state except the
    // flush term that blocks acceptance in IDLE
    always_comb begin
        start_ready_o  = 1'b0;
        init_o         = 1'b0;
        iter_en_o      = 1'b0;
        post_en_o      = 1'b0;
        finish_valid_o = 1'b0;
        case (state_q)
            IDLE: start_ready_o  = ~flush_i;
            INIT: init_o         = 1'b1;
            ITER: iter_en_o      = 1'b1;
            POST: post_en_o      = 1'b1;
            DONE: finish_valid_o = 1'b1;
            default: ;
        endcase
        busy_o = (state_q != IDLE);
    end

    assign iter_cnt_o = iter_cnt_q;
    assign cg_sel_o   = cg_sel_q;

    // A special operand never enters the iteration phases
    always_comb begin
        if (!rst) begin
            assert (!(special_q && (state_q == INIT || state_q == ITER)));
        end
    end

endmodule
